data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Parameter DEPTH_BYTES, default 1024, SHALL set the storage size in bytes; it SHALL be a power of two and at least 4.
REQ-003 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port DMWr, input, 1 bit: write enable.
REQ-006 Port DMCtrl, input, 3 bits: access size and sign control.
REQ-007 Port Address, input, 32 bits: byte address.
REQ-008 Port DataWr, input, 32 bits: store data; the low byte, low half or full word is used according to DMCtrl.
REQ-009 Port DataRd, output, 32 bits: load data, extended to 32 bits.

Function
REQ-010 Storage SHALL be a byte-addressed array of DEPTH_BYTES bytes, indexed by Address[log2(DEPTH_BYTES)-1:0]; upper address bits SHALL be ignored, so addresses alias modulo DEPTH_BYTES.
REQ-011 DMCtrl encoding SHALL be:
- 000: word
- 001: byte, sign-extended
- 010: half-word, sign-extended
- 011: byte, zero-extended
- 100: half-word, zero-extended
- 101, 110 and 111: treated as word
REQ-012 Data SHALL be stored little-endian: byte k of the access goes to address A+k.
REQ-013 Writes SHALL occur on the rising edge of clk when rst_n=1 and DMWr=1:
- byte sizes write DataWr[7:0] to A
- half sizes write DataWr[15:0] to A and A+1
- word sizes write DataWr[31:0] to A through A+3
REQ-014 Bytes outside the access width SHALL remain unchanged.
REQ-015 Misaligned accesses SHALL be permitted; each byte index SHALL be computed as (A+k) mod DEPTH_BYTES, so an access at the top of memory wraps to byte 0.
REQ-016 DataRd SHALL be combinational, with zero latency, from the current Address, DMCtrl and array contents, independent of DMWr.
REQ-017 DataRd SHALL be produced per access size:
- byte sizes: the byte at A, sign- or zero-extended per DMCtrl
- half sizes: bytes A and A+1, sign- or zero-extended per DMCtrl
- word sizes: bytes A through A+3
REQ-018 When DMWr=1, DataRd SHALL show the pre-write contents until the clock edge and the new contents after it; there is no write-through forwarding.
REQ-019 Changing DMCtrl SHALL change only DataRd interpretation and SHALL never alter stored data unless a write occurs.

Reset
REQ-020 On a rising edge with rst_n=0, every storage byte SHALL be cleared to 0x00, and no write SHALL occur even if DMWr=1; reset has priority over write.
REQ-021 After reset, DataRd SHALL be 0x00000000 for every address and every DMCtrl value.
REQ-022 Reset SHALL have no asynchronous effect; array contents SHALL be unchanged until the next clock edge.
REQ-023 Before the first reset, array contents are undefined.

Structure
REQ-024 A shared package data_memory_pkg SHALL hold:
- the DMCtrl encodings as named 3-bit localparams (DM_WORD, DM_BYTE_S, DM_HALF_S, DM_BYTE_U, DM_HALF_U)
- the default DEPTH_BYTES
REQ-025 One sub-module, data_memory_load_ext, SHALL be purely combinational: it takes the four read bytes and DMCtrl and produces the 32-bit extended DataRd.
REQ-026 The storage array, address wrap logic and write-enable decoding SHALL reside in data_memory.

Verification
REQ-027 Word round-trip: reset; write 0xABCD1234 at 0x0 with DMCtrl=000; read 0x0 with 000 -> 0xABCD1234; read 0x0 with 001 -> 0x00000034; read 0x0 with 010 -> 0x00001234.
REQ-028 Signed byte: write 0x000000FF at 0x4 with DMCtrl=001; read with 001 -> 0xFFFFFFFF; read with 011 -> 0x000000FF; read 0x4 with 000 -> 0x000000FF.
REQ-029 Signed half: write 0x0000FFFF at 0x8 with DMCtrl=010; read with 010 -> 0xFFFFFFFF; read with 100 -> 0x0000FFFF.
REQ-030 Partial-write preservation: write word 0x11223344 at 0xC, then byte 0xAA at 0xD (DMCtrl=001); read word at 0xC -> 0x1122AA44.
REQ-031 Wrap and misalignment: write word 0xDEADBEEF at DEPTH_BYTES-2; read byte at 0x0 with DMCtrl=011 -> 0x000000AD; read word at DEPTH_BYTES-2 -> 0xDEADBEEF; read at DEPTH_BYTES+0x0 aliases to 0x0.
REQ-032 Reset priority: with rst_n=0 and DMWr=1 writing 0xFFFFFFFF at 0x0 for one edge -> read word at 0x0 = 0x00000000; also, a read with DMWr=1 before the edge -> old value, and after the edge -> new value.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared definitions for the byte-addressed data memory: DMCtrl encodings,
// default storage size and access-size decoding.
package data_memory_pkg;

    // DMCtrl encodings (unlisted codes behave as word accesses)
    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_BYTE_S = 3'b001;
    localparam logic [2:0] DM_HALF_S = 3'b010;
    localparam logic [2:0] DM_BYTE_U = 3'b011;
    localparam logic [2:0] DM_HALF_U = 3'b100;

    // Default storage size in bytes (power of two, at least 4)
    localparam int DEPTH_BYTES_DEFAULT = 1024;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    // Map a DMCtrl code to the number of bytes it touches.
    function automatic access_size_e decode_size(input logic [2:0] ctrl);
        case (ctrl)
            DM_BYTE_S, DM_BYTE_U: decode_size = SZ_BYTE;
            DM_HALF_S, DM_HALF_U: decode_size = SZ_HALF;
            default:              decode_size = SZ_WORD;
        endcase
    endfunction

    // True when the DMCtrl code asks for sign extension of a narrow load.
    function automatic logic is_signed_load(input logic [2:0] ctrl);
        is_signed_load = (ctrl == DM_BYTE_S) || (ctrl == DM_HALF_S);
    endfunction

endpackage

// File: rtl/data_memory_load_ext.sv
// Load formatter: turns the four bytes read at A..A+3 into the 32-bit
// load result, selecting width and sign/zero extension from DMCtrl.
module data_memory_load_ext
    import data_memory_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] data
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    access_size_e       size;
    logic               sext;

    assign byte_s = $signed(raw[7:0]);
    assign half_s = $signed(raw[15:0]);
    assign size   = decode_size(DMCtrl);
    assign sext   = is_signed_load(DMCtrl);

    // Select access width and apply the requested extension.
    always_comb begin
        data = raw;
        case (size)
            SZ_BYTE: data = sext ? 32'(byte_s) : {24'h000000, raw[7:0]};
            SZ_HALF: data = sext ? 32'(half_s) : {16'h0000, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory with synchronous active-low
// clear, byte/half/word stores and a combinational, zero-latency load path.
// Addresses alias modulo DEPTH_BYTES and multi-byte accesses wrap at the top.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_BYTES = DEPTH_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    output logic [31:0] DataRd
);

    localparam int AW = $clog2(DEPTH_BYTES);

    logic [7:0]    mem [DEPTH_BYTES];

    logic [AW-1:0] idx0;
    logic [AW-1:0] idx1;
    logic [AW-1:0] idx2;
    logic [AW-1:0] idx3;
    logic [31:0]   raw;
    access_size_e  size;
    logic          wr_half;
    logic          wr_word;

    // Upper address bits only select an alias of the same storage.
    logic          unused_addr;
    assign unused_addr = ^Address[31:AW];

    // Byte indices for A..A+3; the AW-bit adds wrap modulo DEPTH_BYTES.
    always_comb begin
        idx0 = Address[AW-1:0];
        idx1 = Address[AW-1:0] + AW'(1);
        idx2 = Address[AW-1:0] + AW'(2);
        idx3 = Address[AW-1:0] + AW'(3);
    end

    // Decode which bytes beyond the first a store touches.
    always_comb begin
        size    = decode_size(DMCtrl);
        wr_half = (size == SZ_HALF) || (size == SZ_WORD);
        wr_word = (size == SZ_WORD);
    end

    // Storage update: clear takes priority over any store on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (DMWr) begin
            mem[idx0] <= DataWr[7:0];
            if (wr_half) begin
                mem[idx1] <= DataWr[15:8];
            end
            if (wr_word) begin
                mem[idx2] <= DataWr[23:16];
                mem[idx3] <= DataWr[31:24];
            end
        end
    end

    // Gather the four bytes at A..A+3 little-endian; no store forwarding.
    always_comb begin
        raw = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
    end

    data_memory_load_ext u_load_ext (
        .raw    (raw),
        .DMCtrl (DMCtrl),
        .data   (DataRd)
    );

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: expected load values are queued when the
// stimulus is applied and popped for comparison once DataRd has settled.
module tb_data_memory;

    localparam int D = 1024;

    logic        clk;
    logic        rst_n;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic [31:0] DataRd;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;

    data_memory #(.DEPTH_BYTES(D)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .DMWr    (DMWr),
        .DMCtrl  (DMCtrl),
        .Address (Address),
        .DataWr  (DataWr),
        .DataRd  (DataRd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue an expectation for the current inputs, let DataRd settle, compare.
    task automatic expect_now(input string tag, input logic [31:0] val);
        exp_t e;
        exp_t got;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
        #1;
        got = exp_q.pop_front();
        total++;
        assert (DataRd === got.val)
        else begin
            bad++;
            $error("FAIL %s: DataRd=%08h expected=%08h", got.tag, DataRd, got.val);
        end
    endtask

    // Apply a read address/control mid-cycle and check the load result.
    task automatic expect_rd(input string tag, input logic [31:0] addr,
                             input logic [2:0] ctrl, input logic [31:0] val);
        @(negedge clk);
        Address = addr;
        DMCtrl  = ctrl;
        expect_now(tag, val);
    endtask

    // One store cycle.
    task automatic store(input logic [31:0] addr, input logic [2:0] ctrl,
                         input logic [31:0] data);
        @(negedge clk);
        Address = addr;
        DMCtrl  = ctrl;
        DataWr  = data;
        DMWr    = 1'b1;
        @(posedge clk);
        #1;
        DMWr    = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        DMWr    = 1'b0;
        DMCtrl  = 3'b000;
        Address = 32'h0;
        DataWr  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Cleared contents read as zero under every control code
        for (int c = 0; c < 8; c++) begin
            expect_rd($sformatf("rst_ctrl%0d", c), 32'h0, 3'(c), 32'h0);
        end
        expect_rd("rst_top_wrap", D - 1, 3'b000, 32'h0);
        expect_rd("rst_mid", 32'h0000_0155, 3'b010, 32'h0);

        // Word round-trip and reinterpretation
        store(32'h0, 3'b000, 32'hABCD1234);
        expect_rd("w_word",   32'h0, 3'b000, 32'hABCD1234);
        expect_rd("w_byte_s", 32'h0, 3'b001, 32'h00000034);
        expect_rd("w_half_s", 32'h0, 3'b010, 32'h00001234);
        expect_rd("w_byte_u", 32'h0, 3'b011, 32'h00000034);
        expect_rd("w_half_u", 32'h0, 3'b100, 32'h00001234);
        expect_rd("w_ctrl5",  32'h0, 3'b101, 32'hABCD1234);
        expect_rd("w_ctrl6",  32'h0, 3'b110, 32'hABCD1234);
        expect_rd("w_ctrl7",  32'h0, 3'b111, 32'hABCD1234);
        expect_rd("w_misal1", 32'h1, 3'b000, 32'h00ABCD12);
        expect_rd("w_half_s_hi", 32'h2, 3'b010, 32'hFFFFABCD);

        // Signed byte
        store(32'h4, 3'b001, 32'h000000FF);
        expect_rd("b_s",    32'h4, 3'b001, 32'hFFFFFFFF);
        expect_rd("b_u",    32'h4, 3'b011, 32'h000000FF);
        expect_rd("b_word", 32'h4, 3'b000, 32'h000000FF);
        expect_rd("b_keep0", 32'h0, 3'b000, 32'hABCD1234);

        // Signed half
        store(32'h8, 3'b010, 32'h0000FFFF);
        expect_rd("h_s",    32'h8, 3'b010, 32'hFFFFFFFF);
        expect_rd("h_u",    32'h8, 3'b100, 32'h0000FFFF);
        expect_rd("h_word", 32'h8, 3'b000, 32'h0000FFFF);

        // Partial-write preservation; only low byte/half of DataWr is used
        store(32'hC, 3'b000, 32'h11223344);
        store(32'hD, 3'b001, 32'h555555AA);
        expect_rd("p_byte", 32'hC, 3'b000, 32'h1122AA44);
        store(32'hE, 3'b100, 32'h9999BEEF);
        expect_rd("p_half", 32'hC, 3'b000, 32'hBEEFAA44);
        expect_rd("p_misal_half", 32'hD, 3'b010, 32'hFFFFEFAA);

        // Wrap at the top and address aliasing
        store(D - 2, 3'b000, 32'hDEADBEEF);
        expect_rd("wr_byte0", 32'h0, 3'b011, 32'h000000AD);
        expect_rd("wr_word",  D - 2, 3'b000, 32'hDEADBEEF);
        expect_rd("wr_alias", D,     3'b000, 32'hABCDDEAD);
        expect_rd("wr_base",  32'h0, 3'b000, 32'hABCDDEAD);
        expect_rd("wr_hiaddr", 32'hFFFF_F400, 3'b000, 32'hABCDDEAD);
        expect_rd("wr_half",  D - 1, 3'b100, 32'h0000ADBE);

        // No forwarding: old value before the edge, new value after
        @(negedge clk);
        Address = 32'h20;
        DMCtrl  = 3'b000;
        DataWr  = 32'h0BADF00D;
        DMWr    = 1'b1;
        expect_now("fw_word_pre", 32'h0);
        @(posedge clk);
        expect_now("fw_word_post", 32'h0BADF00D);
        @(negedge clk);
        Address = 32'h24;
        DMCtrl  = 3'b001;
        DataWr  = 32'h00000080;
        expect_now("fw_byte_pre", 32'h0);
        @(posedge clk);
        expect_now("fw_byte_post", 32'hFFFFFF80);
        DMWr = 1'b0;

        // Reset beats a simultaneous store and acts only at the edge
        @(negedge clk);
        rst_n   = 1'b0;
        DMWr    = 1'b1;
        Address = 32'h0;
        DMCtrl  = 3'b000;
        DataWr  = 32'hFFFFFFFF;
        expect_now("rp_pre_edge", 32'hABCDDEAD);
        @(posedge clk);
        expect_now("rp_post_edge", 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        DMWr  = 1'b0;
        expect_rd("rp_word0",  32'h0,  3'b000, 32'h0);
        expect_rd("rp_w20",    32'h20, 3'b000, 32'h0);
        expect_rd("rp_top",    D - 2,  3'b000, 32'h0);
        expect_rd("rp_c_byte", 32'hC,  3'b001, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
